spi_xfer_queue: RTL



---
 rtl/spi_xfer_queue.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_xfer_queue.sv
// Command/response queue in front of an SPI master: TX FIFO -> one transfer at a time -> RX FIFO.
// Optional per-transfer timeout is compiled in with `define SPI_QUEUE_TIMEOUT_EN.
module spi_xfer_queue #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     tx_wr_i,
    input  logic [31:0]              tx_data_i,
    input  logic [2:0]               tx_bytes_i,
    output logic                     tx_full_o,
    output logic [$clog2(DEPTH):0]   tx_level_o,
    input  logic                     rx_rd_i,
    output logic [31:0]              rx_data_o,
    output logic [2:0]               rx_bytes_o,
    output logic                     rx_empty_o,
    output logic [$clog2(DEPTH):0]   rx_level_o,
    output logic [2:0]               err_o,
    input  logic                     err_clr_i,
    output logic                     busy_o,
    output logic                     spi_enable_o,
    output logic [31:0]              spi_write_data_o,
    output logic [2:0]               spi_write_data_bytes_valid_o,
    input  logic                     spi_ready_i,
    input  logic [31:0]              spi_read_data_i,
    input  logic [2:0]               spi_read_data_bytes_valid_i
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitBusy,
        StWaitDone,
        StCapture
    } state_e;

    state_e state_q;

    // TX FIFO
    logic [31:0]   tx_data_mem  [DEPTH];
    logic [2:0]    tx_bytes_mem [DEPTH];
    logic [PW:0]   tx_wptr_q, tx_rptr_q;
    logic [PW:0]   tx_level;
    logic          tx_full, tx_empty, tx_push, tx_pop;
    logic [31:0]   tx_head_data;
    logic [2:0]    tx_head_bytes;

    // RX FIFO
    logic [31:0]   rx_data_mem  [DEPTH];
    logic [2:0]    rx_bytes_mem [DEPTH];
    logic [PW:0]   rx_wptr_q, rx_rptr_q;
    logic [PW:0]   rx_level;
    logic          rx_full, rx_empty, rx_push, rx_pop;

    logic          head_bad, launch, drop_bad, timeout_hit;
    logic [2:0]    err_q, err_d;
    logic          enable_q;
    logic [31:0]   wdata_q;
    logic [2:0]    wbytes_q;

`ifdef SPI_QUEUE_TIMEOUT_EN
    logic [31:0]   tmo_cnt_q;
`endif

    always_comb begin
        tx_level      = tx_wptr_q - tx_rptr_q;
        tx_full       = (tx_level == LW'(DEPTH));
        tx_empty      = (tx_level == '0);
        tx_head_data  = tx_data_mem[tx_rptr_q[PW-1:0]];
        tx_head_bytes = tx_bytes_mem[tx_rptr_q[PW-1:0]];
        rx_level      = rx_wptr_q - rx_rptr_q;
        rx_full       = (rx_level == LW'(DEPTH));
        rx_empty      = (rx_level == '0);

        head_bad = (tx_head_bytes == 3'd0) || (tx_head_bytes > 3'd4);
        drop_bad = (state_q == StIdle) && !tx_empty && head_bad;
        // RX-full backpressure is applied here so a capture always has room.
        launch   = (state_q == StIdle) && !tx_empty && !head_bad && !rx_full && spi_ready_i;
        tx_push  = tx_wr_i && !tx_full;
        tx_pop   = drop_bad || launch;
        rx_push  = (state_q == StCapture);
        rx_pop   = rx_rd_i && !rx_empty;
    end

`ifdef SPI_QUEUE_TIMEOUT_EN
    always_comb begin
        timeout_hit = ((state_q == StWaitBusy) || (state_q == StWaitDone)) &&
                      (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));
    end
`else
    always_comb begin
        timeout_hit = 1'b0;
    end
`endif

    always_comb begin
        if (err_clr_i) begin
            err_d = 3'b000;
        end else begin
            err_d = err_q | {timeout_hit, drop_bad, tx_wr_i && tx_full};
        end
    end

    // Storage arrays carry no reset; outputs are qualified by the pointers.
    always_ff @(posedge clk_i) begin
        if (tx_push) begin
            tx_data_mem[tx_wptr_q[PW-1:0]]  <= tx_data_i;
            tx_bytes_mem[tx_wptr_q[PW-1:0]] <= tx_bytes_i;
        end
        if (rx_push) begin
            rx_data_mem[rx_wptr_q[PW-1:0]]  <= spi_read_data_i;
            rx_bytes_mem[rx_wptr_q[PW-1:0]] <= spi_read_data_bytes_valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
            if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            enable_q <= 1'b0;
            wdata_q  <= '0;
            wbytes_q <= '0;
            err_q    <= '0;
`ifdef SPI_QUEUE_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            err_q    <= err_d;
            enable_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (launch) begin
                        wdata_q  <= tx_head_data;
                        wbytes_q <= tx_head_bytes;
                        enable_q <= 1'b1;
                        state_q  <= StLaunch;
                    end
                end
                StLaunch: begin
                    state_q <= StWaitBusy;
`ifdef SPI_QUEUE_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end
                StWaitBusy: begin
                    if (timeout_hit) begin
                        state_q <= StIdle;
                    end else if (!spi_ready_i) begin
                        state_q <= StWaitDone;
                    end
`ifdef SPI_QUEUE_TIMEOUT_EN
                    tmo_cnt_q <= tmo_cnt_q + 32'd1;
`endif
                end
                StWaitDone: begin
                    if (timeout_hit) begin
                        state_q <= StIdle;
                    end else if (spi_ready_i) begin
                        state_q <= StCapture;
                    end
`ifdef SPI_QUEUE_TIMEOUT_EN
                    tmo_cnt_q <= tmo_cnt_q + 32'd1;
`endif
                end
                StCapture: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        tx_full_o                    = tx_full;
        tx_level_o                   = tx_level;
        rx_empty_o                   = rx_empty;
        rx_level_o                   = rx_level;
        rx_data_o                    = rx_empty ? 32'd0 : rx_data_mem[rx_rptr_q[PW-1:0]];
        rx_bytes_o                   = rx_empty ? 3'd0 : rx_bytes_mem[rx_rptr_q[PW-1:0]];
        err_o                        = err_q;
        busy_o                       = (state_q != StIdle);
        spi_enable_o                 = enable_q;
        spi_write_data_o             = wdata_q;
        spi_write_data_bytes_valid_o = wbytes_q;
    end

endmodule
